// File: rtl/advtim_oc_bank.sv
// Output-compare bank for the advanced-timer PWM engine.
// Shadowed compares, edge match flags, sticky modes and ocref-clear.
module advtim_oc_bank #(
  parameter int NCH     = 6,
  parameter int CW      = 16,
  parameter int COMB_CH = 4
) (
  input  logic              pe_gen_clk,
  input  logic              pe_gen_rst,
  input  logic              timing_enable,
  input  logic [CW-1:0]     arr_cnt,
  input  logic              dir,
  input  logic              update_evt,
  input  logic              oc_clr,
  input  logic [NCH*CW-1:0] r_cc,
  input  logic [NCH*4-1:0]  r_ocm,
  input  logic [NCH-1:0]    r_ocpe,
  input  logic [NCH-1:0]    r_occe,
  input  logic [NCH-1:0]    r_comb,
  output logic [NCH-1:0]    ocrefc,
  output logic [NCH-1:0]    occombref,
  output logic [NCH-1:0]    cc_match
);

  logic [CW-1:0]  r_cc_act [NCH];
  logic [NCH-1:0] r_eq_d;
  logic [NCH-1:0] r_clr_lat;
  logic [NCH-1:0] r_ocref;
  logic [NCH-1:0] r_match;

  logic [NCH-1:0] w_eq;
  logic [NCH-1:0] w_ge;
  logic [NCH-1:0] w_lt;
  logic [NCH-1:0] w_rise;
  logic [NCH-1:0] w_clr;
  logic [NCH-1:0] w_clr_nxt;
  logic [NCH-1:0] w_ref_nxt;
  logic           w_gate;

  always_comb begin
    w_eq = '0;
    w_ge = '0;
    w_lt = '0;
    for (int i = 0; i < NCH; i++) begin
      w_eq[i] = (arr_cnt == r_cc_act[i]);
      w_ge[i] = (arr_cnt >= r_cc_act[i]);
      w_lt[i] = (arr_cnt <  r_cc_act[i]);
    end
  end

  always_comb begin
    w_rise    = '0;
    w_clr     = '0;
    w_clr_nxt = '0;
    w_ref_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      int         p;
      int         e;
      int         o;
      logic [3:0] m;
      logic       v;
      p = i ^ 1;
      e = i - (i % 2);
      o = e + 1;
      m = r_ocm[i*4 +: 4];
      v = 1'b0;
      w_rise[i] = w_eq[i] & ~r_eq_d[i];
      // A clear request blanks the output in the same cycle it arrives
      w_clr[i]  = r_clr_lat[i] | (oc_clr & r_occe[i]);
      if (oc_clr & r_occe[i])
        w_clr_nxt[i] = 1'b1;
      else if (update_evt & ~oc_clr)
        w_clr_nxt[i] = 1'b0;
      else
        w_clr_nxt[i] = r_clr_lat[i];
      unique case (m)
        4'h0:    v = r_ocref[i];
        4'h1:    v = w_rise[i] ? 1'b1 : r_ocref[i];
        4'h2:    v = w_rise[i] ? 1'b0 : r_ocref[i];
        4'h3:    v = w_rise[i] ? ~r_ocref[i] : r_ocref[i];
        4'h4:    v = 1'b1;
        4'h5:    v = 1'b0;
        4'h6:    v = w_ge[i];
        4'h7:    v = w_lt[i];
        4'hc:    v = w_ge[i] | w_ge[p];
        4'hd:    v = w_lt[i] & w_lt[p];
        4'he:    v = dir ? w_ge[o] : w_ge[e];
        4'hf:    v = dir ? w_lt[o] : w_lt[e];
        default: v = 1'b0;
      endcase
      w_ref_nxt[i] = timing_enable & ~w_clr[i] & v;
    end
  end

  always_ff @(posedge pe_gen_clk) begin
    if (pe_gen_rst) begin
      for (int i = 0; i < NCH; i++)
        r_cc_act[i] <= '0;
      r_eq_d    <= '0;
      r_clr_lat <= '0;
      r_ocref   <= '0;
      r_match   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        if (!r_ocpe[i] || update_evt)
          r_cc_act[i] <= r_cc[i*CW +: CW];
      r_eq_d    <= timing_enable ? w_eq : '0;
      r_match   <= w_rise & {NCH{timing_enable}};
      r_ocref   <= w_ref_nxt;
      r_clr_lat <= w_clr_nxt;
    end
  end

  assign w_gate    = r_ocref[COMB_CH];
  assign ocrefc    = r_ocref;
  assign cc_match  = r_match;
  assign occombref = r_ocref & (~r_comb | {NCH{w_gate}});

endmodule

// File: tb/tb_advtim_oc_bank.sv
// Directed bench for advtim_oc_bank.
// Inputs change 1ns after a rising edge; outputs are read there too.
module tb_advtim_oc_bank;

  localparam int NCH = 6;
  localparam int CW  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              te;
  logic [CW-1:0]     cnt;
  logic              dir;
  logic              upd;
  logic              clr;
  logic [NCH*CW-1:0] cc;
  logic [NCH*4-1:0]  ocm;
  logic [NCH-1:0]    ocpe;
  logic [NCH-1:0]    occe;
  logic [NCH-1:0]    comb;
  logic [NCH-1:0]    ref_o;
  logic [NCH-1:0]    cref_o;
  logic [NCH-1:0]    match_o;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses;
  int pulse_at;

  always #5 clk = ~clk;

  advtim_oc_bank #(.NCH(NCH), .CW(CW), .COMB_CH(4)) dut (
    .pe_gen_clk   (clk),
    .pe_gen_rst   (rst),
    .timing_enable(te),
    .arr_cnt      (cnt),
    .dir          (dir),
    .update_evt   (upd),
    .oc_clr       (clr),
    .r_cc         (cc),
    .r_ocm        (ocm),
    .r_ocpe       (ocpe),
    .r_occe       (occe),
    .r_comb       (comb),
    .ocrefc       (ref_o),
    .occombref    (cref_o),
    .cc_match     (match_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int c);
    cnt = CW'(c);
    tick();
    if (match_o[0]) begin
      pulses++;
      pulse_at = c;
    end
  endtask

  task automatic set_cc(input int ch, input int v);
    cc[ch*CW +: CW] = CW'(v);
  endtask

  task automatic set_m(input int ch, input logic [3:0] m);
    ocm[ch*4 +: 4] = m;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    te   = 1'b0;
    cnt  = '0;
    dir  = 1'b0;
    upd  = 1'b0;
    clr  = 1'b0;
    cc   = '0;
    ocm  = '0;
    ocpe = '0;
    occe = '0;
    comb = '0;
    tick();
    tick();
    rst  = 1'b0;
    pulses   = 0;
    pulse_at = -1;
  endtask

  initial begin
    do_reset();
    chk("rst_ref", 32'(ref_o), 32'h0);
    chk("rst_match", 32'(match_o), 32'h0);
    chk("rst_comb", 32'(cref_o), 32'h0);

    // T1 PWM1 at 100, no preload
    set_m(0, 4'h6);
    set_cc(0, 100);
    cyc(0);
    te = 1'b1;
    pulses = 0;
    for (int c = 0; c < 200; c++) begin
      cyc(c);
      if (c == 99)  chk("t1_ref99", 32'(ref_o[0]), 32'h0);
      if (c == 100) chk("t1_ref100", 32'(ref_o[0]), 32'h1);
      if (c == 199) chk("t1_ref199", 32'(ref_o[0]), 32'h1);
    end
    chk("t1_pulses", 32'(pulses), 32'd1);
    chk("t1_pulse_at", 32'(pulse_at), 32'd100);

    // T2 preload: 100 -> 50 mid-period
    do_reset();
    set_m(0, 4'h6);
    set_cc(0, 100);
    cyc(0);
    ocpe[0] = 1'b1;
    te = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (c == 60)  set_cc(0, 50);
      if (c == 199) upd = 1'b1;
      cyc(c);
      upd = 1'b0;
      if (c == 70)  chk("t2_ref70", 32'(ref_o[0]), 32'h0);
      if (c == 100) chk("t2_ref100", 32'(ref_o[0]), 32'h1);
    end
    for (int c = 0; c <= 60; c++) begin
      cyc(c);
      if (c == 49) chk("t2_ref49", 32'(ref_o[0]), 32'h0);
      if (c == 50) chk("t2_ref50", 32'(ref_o[0]), 32'h1);
    end

    // T3 toggle with counter stalled on the compare value
    do_reset();
    set_m(0, 4'h3);
    set_cc(0, 10);
    cyc(0);
    te = 1'b1;
    pulses = 0;
    cyc(8);
    cyc(9);
    chk("t3_ref9", 32'(ref_o[0]), 32'h0);
    for (int k = 0; k < 4; k++) cyc(10);
    cyc(11);
    cyc(12);
    chk("t3_ref_end", 32'(ref_o[0]), 32'h1);
    chk("t3_pulses", 32'(pulses), 32'd1);

    // T4 combined/asymmetric modes on pair 0/1
    do_reset();
    set_m(0, 4'hc);
    set_m(1, 4'h6);
    set_cc(0, 30);
    set_cc(1, 70);
    cyc(0);
    te = 1'b1;
    for (int c = 0; c < 100; c++) begin
      cyc(c);
      if (c == 29) chk("t4_c29", 32'(ref_o[1:0]), 32'h0);
      if (c == 30) chk("t4_c30", 32'(ref_o[1:0]), 32'h1);
      if (c == 70) chk("t4_c70", 32'(ref_o[1:0]), 32'h3);
    end
    set_m(0, 4'hd);
    cyc(20);
    cyc(20);
    chk("t4_d20", 32'(ref_o[0]), 32'h1);
    cyc(50);
    chk("t4_d50", 32'(ref_o[0]), 32'h0);
    set_m(0, 4'he);
    cyc(50);
    chk("t4_e_up", 32'(ref_o[0]), 32'h1);
    dir = 1'b1;
    cyc(50);
    chk("t4_e_dn", 32'(ref_o[0]), 32'h0);
    dir = 1'b0;

    // T5 ocref clear and release on update
    do_reset();
    set_m(0, 4'h6);
    set_cc(0, 100);
    occe[0] = 1'b1;
    cyc(0);
    te = 1'b1;
    for (int c = 0; c < 200; c++) begin
      clr = (c == 120 || c == 199);
      upd = (c == 199);
      cyc(c);
      if (c == 119) chk("t5_ref119", 32'(ref_o[0]), 32'h1);
      if (c == 120) chk("t5_ref120", 32'(ref_o[0]), 32'h0);
      if (c == 150) chk("t5_ref150", 32'(ref_o[0]), 32'h0);
    end
    clr = 1'b0;
    upd = 1'b0;
    for (int c = 0; c < 200; c++) begin
      upd = (c == 199);
      cyc(c);
      if (c == 100) begin
        chk("t5_held", 32'(ref_o[0]), 32'h0);
        chk("t5_match", 32'(match_o[0]), 32'h1);
      end
      if (c == 199) chk("t5_ref199", 32'(ref_o[0]), 32'h0);
    end
    upd = 1'b0;
    for (int c = 0; c <= 100; c++) begin
      cyc(c);
      if (c == 99)  chk("t5_rel99", 32'(ref_o[0]), 32'h0);
      if (c == 100) chk("t5_rel100", 32'(ref_o[0]), 32'h1);
    end

    // T6 combined reference gated by channel 4
    do_reset();
    comb[1] = 1'b1;
    set_m(1, 4'h6);
    set_m(4, 4'h7);
    set_cc(1, 20);
    set_cc(4, 80);
    cyc(0);
    te = 1'b1;
    for (int c = 0; c < 100; c++) begin
      cyc(c);
      if (c == 10) chk("t6_c10", 32'(cref_o), 32'h10);
      if (c == 19) chk("t6_c19", 32'(cref_o[1]), 32'h0);
      if (c == 20) chk("t6_c20", 32'(cref_o[1]), 32'h1);
      if (c == 79) chk("t6_c79", 32'(cref_o[1]), 32'h1);
      if (c == 80) chk("t6_c80", 32'(cref_o), 32'h0);
    end

    // Disabled counter forces outputs low
    te = 1'b0;
    cyc(50);
    chk("te_off_ref", 32'(ref_o), 32'h0);
    chk("te_off_match", 32'(match_o), 32'h0);

    // Wrap with compare at zero stays high
    set_m(2, 4'h6);
    set_cc(2, 0);
    cyc(0);
    te = 1'b1;
    cyc(65535);
    chk("wrap_ffff", 32'(ref_o[2]), 32'h1);
    cyc(0);
    chk("wrap_0", 32'(ref_o[2]), 32'h1);
    chk("wrap_match", 32'(match_o[2]), 32'h1);

    // Reset in the middle of operation
    rst = 1'b1;
    tick();
    chk("mid_rst_ref", 32'(ref_o), 32'h0);
    chk("mid_rst_match", 32'(match_o), 32'h0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
